// File: rtl/alu_issue_stage.sv
`timescale 1ns/1ps
// alu_issue_stage: instruction FIFO, two-entry register file and issue/writeback
// sequencer wrapped around a combinational MIPS alu. One instruction sits on the
// alu per cycle; its result is written back on the edge that issues the next one.
module alu_issue_stage #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        hold,
  input  logic        ld_en,
  input  logic        ld_sel,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic [31:0] reg_a,
  output logic [31:0] reg_b,
  output logic [2:0]  last_flags,
  output logic        ovf_err,
  output logic [15:0] retired,
  output logic        busy
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          push;
  logic          pop;
  logic          retire;

  logic [5:0]    op;
  logic [4:0]    wb_addr;
  logic          no_wb;
  logic          wb_en;
  logic          wb_a;
  logic          wb_b;
  logic [31:0]   reg_a_next;
  logic [31:0]   reg_b_next;

  assign in_ready = (count < DEPTH_CNT);
  assign push     = in_valid && in_ready;
  // Pop whenever not held and work is queued: in IDLE this starts execution,
  // in EXEC it follows the retire of the current instruction on the same edge.
  assign pop      = !hold && (count != '0);
  assign retire   = (state == EXEC) && !hold;
  assign busy     = (state == EXEC) || (count != '0);

  // Decode the instruction currently on the alu for writeback.
  always_comb begin
    op      = alu_instruction[31:26];
    wb_addr = (op == OP_RTYPE) ? alu_instruction[15:11] : alu_instruction[20:16];
    no_wb   = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    wb_en   = retire && !no_wb && !alu_flags[0];
    wb_a    = wb_en && (wb_addr == 5'd0);
    wb_b    = wb_en && (wb_addr != 5'd0);
  end

  // Post-edge register values: writeback beats a preload to the same register.
  // These also feed the operand snapshot, giving full forwarding at issue.
  always_comb begin
    reg_a_next = reg_a;
    reg_b_next = reg_b;
    if (wb_a) begin
      reg_a_next = alu_result;
    end else if (ld_en && !ld_sel) begin
      reg_a_next = ld_data;
    end
    if (wb_b) begin
      reg_b_next = alu_result;
    end else if (ld_en && ld_sel) begin
      reg_b_next = ld_data;
    end
  end

  // Next-state logic for the issue sequencer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (pop) state_next = EXEC;
      EXEC: if (retire) state_next = pop ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO storage (contents need no reset; count/pointers gate visibility).
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_instr;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue register: instruction and operand snapshot presented to the alu.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_instruction <= NOP_INSTR;
      alu_regA        <= '0;
      alu_regB        <= '0;
    end else if (pop) begin
      alu_instruction <= fifo_mem[rd_ptr];
      alu_regA        <= reg_a_next;
      alu_regB        <= reg_b_next;
    end else if (retire) begin
      alu_instruction <= NOP_INSTR;
      alu_regA        <= '0;
      alu_regB        <= '0;
    end
  end

  // Architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      reg_a <= reg_a_next;
      reg_b <= reg_b_next;
    end
  end

  // Retire bookkeeping: flags, sticky overflow and retired counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_flags <= '0;
      ovf_err    <= 1'b0;
      retired    <= '0;
    end else if (retire) begin
      last_flags <= alu_flags;
      retired    <= retired + 16'd1;
      if (alu_flags[0]) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_issue_stage with a behavioural alu stub and an
// in-order architectural reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        hold;
  logic        ld_en;
  logic        ld_sel;
  logic [31:0] ld_data;
  logic [31:0] alu_instruction;
  logic [31:0] alu_regA;
  logic [31:0] alu_regB;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [2:0]  last_flags;
  logic        ovf_err;
  logic [15:0] retired;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(4), .NOP_INSTR(32'h0000_0020)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .hold(hold), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .reg_a(reg_a), .reg_b(reg_b), .last_flags(last_flags),
    .ovf_err(ovf_err), .retired(retired), .busy(busy)
  );

  // Behavioural alu: operand register chosen by address (0 -> regA, else regB).
  function automatic logic [34:0] alu_model(input logic [31:0] ins,
                                            input logic [31:0] ra,
                                            input logic [31:0] rb);
    logic [31:0] x, y, imm, res;
    logic        ovf;
    x   = (ins[25:21] == 5'd0) ? ra : rb;
    y   = (ins[20:16] == 5'd0) ? ra : rb;
    imm = {{16{ins[15]}}, ins[15:0]};
    res = '0;
    ovf = 1'b0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: begin res = x + y; ovf = (x[31] == y[31]) && (res[31] != x[31]); end
          6'h21: res = x + y;
          6'h22: begin res = x - y; ovf = (x[31] != y[31]) && (res[31] != x[31]); end
          6'h23: res = x - y;
          6'h25: res = x | y;
          default: res = '0;
        endcase
      end
      6'h08: begin res = x + imm; ovf = (x[31] == imm[31]) && (res[31] != x[31]); end
      6'h09: res = x + imm;
      6'h04, 6'h05: res = x - y;
      6'h2b: res = x + imm;
      default: res = '0;
    endcase
    return {(ovf ? 3'b001 : {res == 32'd0, res[31], 1'b0}), res};
  endfunction

  assign {alu_flags, alu_result} = alu_model(alu_instruction, alu_regA, alu_regB);

  // Reference model: architectural state after each instruction in program order.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        o;
    logic [15:0] r;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_ret = '0;
  bit          mon_en = 1'b0;
  bit          rand_hold_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [31:0] ins);
    logic [34:0] r;
    logic [5:0]  op;
    logic [4:0]  dst;
    r  = alu_model(ins, m_a, m_b);
    op = ins[31:26];
    if (!(op inside {6'h04, 6'h05, 6'h2b}) && !r[32]) begin
      dst = (op == 6'h00) ? ins[15:11] : ins[20:16];
      if (dst == 5'd0) m_a = r[31:0];
      else             m_b = r[31:0];
    end
    if (r[32]) m_ovf = 1'b1;
    m_ret = m_ret + 16'd1;
    sb.push_back('{a: m_a, b: m_b, f: r[34:32], o: m_ovf, r: m_ret});
  endtask

  task automatic push(input logic [31:0] ins);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int n = 0; n < 500 && !ok; n++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_instr = '0;
    if (ok) model_step(ins);
    else chk("push_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2000 && busy; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic preload(input logic sel, input logic [31:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (sel) m_b = d; else m_a = d;
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom % 2 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = pick_reg(); rt = pick_reg(); rd = pick_reg();
    imm = 16'($urandom);
    case ($urandom % 10)
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      2: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      3: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      4: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      5: return {6'h08, rs, rt, imm};
      6: return {6'h09, rs, rt, imm};
      7: return {6'h04, rs, rt, imm};
      8: return {6'h05, rs, rt, imm};
      default: return {6'h2b, rs, rt, imm};
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom % 4)
      0: return 32'h7FFF_FFFF - 32'($urandom % 4);
      1: return 32'h8000_0000 + 32'($urandom % 4);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every increment of the retire counter pops one expectation.
  initial begin
    logic [15:0] prev = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en && retired != prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'(retired), 32'(prev));
        end else begin
          e = sb.pop_front();
          chk("ret_reg_a", reg_a, e.a);
          chk("ret_reg_b", reg_b, e.b);
          chk("ret_flags", 32'(last_flags), 32'(e.f));
          chk("ret_ovf_err", 32'(ovf_err), 32'(e.o));
          chk("ret_count", 32'(retired), 32'(e.r));
        end
      end
      prev = retired;
    end
  end

  // Random hold driver for the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_hold_en) hold = ($urandom % 4 == 0);
    end
  end

  initial begin
    logic [31:0] ins;
    logic [15:0] ret_before;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; hold = 1'b0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_instr", alu_instruction, 32'h0000_0020);
    chk("rst_reg_a", reg_a, 32'd0);
    chk("rst_reg_b", reg_b, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_alu_regA", alu_regA, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Basic addu with operand latency check.
    preload(1'b0, 32'd5);
    preload(1'b1, 32'd7);
    push(32'h0001_0821);
    @(posedge clk); #1;
    chk("lat_alu_instr", alu_instruction, 32'h0001_0821);
    chk("lat_alu_regA", alu_regA, 32'd5);
    chk("lat_alu_regB", alu_regB, 32'd7);
    wait_idle();
    chk("addu_reg_b", reg_b, 32'd12);

    // addi overflow: no writeback, sticky error.
    preload(1'b0, 32'h7FFF_FFFF);
    push(32'h2000_0001);
    wait_idle();
    chk("ovf_flags", 32'(last_flags), 32'd1);
    chk("ovf_reg_a", reg_a, 32'h7FFF_FFFF);

    // Hold with a full FIFO behind an executing instruction.
    ret_before = m_ret;
    push({6'h09, 5'd1, 5'd1, 16'd1});
    @(posedge clk); #1;
    hold = 1'b1;
    for (int k = 2; k <= 5; k++) push({6'h09, 5'd1, 5'd1, 16'(k)});
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    fork
      push({6'h09, 5'd1, 5'd1, 16'd6});
      begin
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_frozen_instr", alu_instruction, {6'h09, 5'd1, 5'd1, 16'd1});
        chk("hold_frozen_ret", 32'(retired), 32'(ret_before));
        chk("hold_busy", 32'(busy), 32'd1);
        hold = 1'b0;
      end
    join
    wait_idle();
    chk("hold_retired", 32'(retired), 32'(ret_before + 16'd6));

    // Back-to-back forwarding, then a branch with no writeback.
    preload(1'b0, 32'd3);
    preload(1'b1, 32'd4);
    push(32'h0001_0821);
    push(32'h0021_0021);
    push(32'h1001_0003);
    wait_idle();
    chk("fwd_reg_a", reg_a, 32'd14);
    chk("fwd_reg_b", reg_b, 32'd7);

    // Preload colliding with a writeback to the same register.
    push(32'h0001_0821);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_sel = 1'b1; ld_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ld_en = 1'b0;
    wait_idle();
    chk("ldwb_reg_b", reg_b, 32'd21);

    // Randomized traffic.
    rand_hold_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom % 8 == 0) begin
        rand_hold_en = 1'b0;
        @(posedge clk); #1;
        hold = 1'b0;
        wait_idle();
        preload(1'($urandom), rand_val());
        rand_hold_en = 1'b1;
      end
      push(gen_instr());
      repeat ($urandom % 2) begin @(posedge clk); #1; end
    end
    rand_hold_en = 1'b0;
    @(posedge clk); #1;
    hold = 1'b0;
    wait_idle();

    // Reset while an instruction is executing.
    preload(1'b1, 32'd100);
    ins = {6'h09, 5'd1, 5'd1, 16'd5};
    push(ins);
    @(posedge clk); #1;
    chk("rexec_in_exec", alu_instruction, ins);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rexec_alu_instr", alu_instruction, 32'h0000_0020);
    chk("rexec_reg_b", reg_b, 32'd0);
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_retired", 32'(retired), 32'd0);
    chk("rexec_ovf", 32'(ovf_err), 32'd0);
    chk("rexec_flags", 32'(last_flags), 32'd0);
    chk("rexec_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("rexec_no_wb", reg_b, 32'd0);
    rst = 1'b0;
    sb.delete();
    m_a = '0; m_b = '0; m_ovf = 1'b0; m_ret = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    preload(1'b0, 32'd9);
    push(32'h0000_0821);
    wait_idle();
    @(negedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
